ssd_mux_driver: RTL and testbench
=================================

Name: ssd_mux_driver

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a frame buffer of hex nibbles and decodes them to the standard hex glyph set (0-F), one digit per scan slot. It scans the anodes at a programmable refresh rate and swaps in new data only at frame boundaries, so the display never tears. It sits between the control logic and the board display pins; all display outputs are active-low.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 1..8.
REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2.
BLANK_CYCLES, 0, anti-ghosting cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
load  in  1  single-cycle strobe; captures value, dp_in and digit_en
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
an  out  NUM_DIGITS  anode selects, active-low, at most one low at a time
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - cnt=0, idx=0.
  - Pending and active buffers cleared: nibbles 0, dp 0, enables 0.
  - Outputs: an=all 1s, seg=7'h7F, dp=1, frame_tick=0.
  - Reset asserted mid-scan forces this state immediately. First slot after release is digit 0.
- Scan counter:
  - cnt counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - At cnt==REFRESH_DIV-1: cnt wraps to 0 and idx increments, wrapping NUM_DIGITS-1 -> 0.
- Buffering:
  - load=1 copies value/dp_in/digit_en into the pending buffer.
  - At each frame boundary (cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1), active is loaded from pending.
  - If load is asserted on the boundary cycle, active takes the new input directly, bypassing pending, and pending is also updated.
  - Outside boundaries, load never alters active.
  - Multiple loads within one frame: the last one wins.
- Output register:
  - All outputs are registered from the current (cnt, idx, active) state: one cycle of latency.
  - If cnt < BLANK_CYCLES, or the active enable for idx is 0: an=all 1s, seg=7'h7F, dp=1.
  - Otherwise:
    - an = ~(1<<idx).
    - seg = glyph(active nibble idx).
    - dp = ~active dp bit idx.
- Glyph table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- frame_tick: high for exactly one cycle, the cycle after the frame boundary, i.e. aligned with the first output cycle of digit 0. It pulses every frame regardless of enables.
- Boundary cases:
  - NUM_DIGITS=1: idx stays 0 and every slot is a frame boundary.
  - BLANK_CYCLES=0: no blank gap between slots.

Optional Feature:
SSD_LZ_BLANK_EN: leading-zero suppression.
- Defined: digit i (i>=1) is blanked (an bit high, seg 7'h7F, dp 1) when active nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. This is evaluated on the active buffer and ANDed with digit_en.
- Undefined: zeros are always displayed; no extra logic.

Test Plan:
1. Reset release, NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=0, no load -> an=1111, seg=7F, dp=1 for all cycles; frame_tick pulses every 16 cycles.
2. load value=16'h12AF, digit_en=1111, dp_in=0100 -> after the next boundary, slots give:
   - an=1110 seg=0001110
   - an=1101 seg=0001000
   - an=1011 seg=0100100 dp=0
   - an=0111 seg=1111001
3. BLANK_CYCLES=1, REFRESH_DIV=4 -> each slot shows 1 cycle of an=1111 followed by 3 cycles of the active anode; never two anodes low.
4. load 16'h1111, then load 16'h2222 mid-frame -> current frame still shows 1s; next frame shows 2 on all digits (seg=0100100).
5. load asserted exactly on the boundary cycle with 16'h3333 -> first slot of the new frame shows seg=0110000.
6. rst pulsed mid-slot at idx=2 -> outputs blank asynchronously; after release, scan restarts at digit 0 and active is cleared. With SSD_LZ_BLANK_EN and value=16'h0050, digits 3 and 2 stay blank, digit 1 shows 5 and digit 0 shows 0.

Source files
------------

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed hex driver for a common-anode seven-segment display.
// Optional leading-zero suppression is enabled by defining SSD_LZ_BLANK_EN.
module ssd_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, pend_en, act_en;
  logic                    slot_end, frame_end, in_blank;
  logic [NUM_DIGITS-1:0]   visible, an_next;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_on, dp_next;
  logic [6:0]              seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0011000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Comparing against a zero blank width would be a constant-false unsigned test.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);
      assign in_blank = (cnt < BLANK_W);
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

`ifdef SSD_LZ_BLANK_EN
  logic lz_nz;
  // Walk from the most significant digit down; a digit stays lit once any
  // nibble at or above it is non-zero. Digit 0 is always eligible.
  always_comb begin
    lz_nz   = 1'b0;
    visible = act_en;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      lz_nz = lz_nz | (|act_val[4*(NUM_DIGITS-1-k) +: 4]);
      if ((NUM_DIGITS - 1 - k) != 0 && !lz_nz)
        visible[NUM_DIGITS-1-k] = 1'b0;
    end
  end
`else
  assign visible = act_en;
`endif

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_on   = 1'b0;
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = act_val[4*i +: 4];
        cur_dp  = act_dp[i];
        cur_on  = visible[i];
      end
    end
    if (cur_on && !in_blank) begin
      seg_next = glyph(cur_nib);
      dp_next  = ~cur_dp;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        an_next[i] = (idx != IW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
      end
      // A load on the boundary cycle goes straight to the active buffer.
      if (frame_end) begin
        act_val <= load ? value    : pend_val;
        act_dp  <= load ? dp_in    : pend_dp;
        act_en  <= load ? digit_en : pend_en;
      end
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_end ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed bench for ssd_mux_driver: 4 digits, 4 cycles per slot, with and
// without a one-cycle blank gap (two instances on shared stimulus).
module tb_ssd_mux_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en;
  logic        load;
  logic [6:0]  seg, seg_b;
  logic        dp, dp_b;
  logic [3:0]  an, an_b;
  logic        frame_tick, tick_b;

  int k;
  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  ssd_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  ssd_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(tick_b)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpv;
    logic [3:0]      en;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs[5];

  localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d {an,seg,dp,tick} got=%b want=%b", name, k, got, exp);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle", {an, seg, dp, frame_tick}, {BLANK, 1'((k - 1) % 16 == 0)});
      chk("idle_b", {an_b, seg_b, dp_b, tick_b}, {BLANK, 1'((k - 1) % 16 == 0)});
    end
  endtask

  task automatic load_vec(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] en);
    value    = v;
    dp_in    = dpv;
    digit_en = en;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic wait_frame();
    int b;
    b = 0;
    step();
    while (((k - 1) % 16) != 0 && b < 40) begin
      step();
      b++;
    end
    if (((k - 1) % 16) != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_frame k=%0d got=timeout want=frame_start", k);
    end
  endtask

  // Checks the 16 samples of one frame; optional loads at sample 5 and 9.
  task automatic check_frame(input string name, input logic [3:0][6:0] s,
                             input logic [3:0] dpo, input logic [3:0] vis,
                             input logic [1:0] mid, input logic [15:0] v5,
                             input logic [15:0] v9);
    int          d;
    logic [3:0]  ea;
    logic [12:0] e, eb;
    for (int j = 0; j < 16; j++) begin
      d  = j / 4;
      ea = vis[d] ? ~(4'b0001 << d) : 4'hF;
      e  = {ea, vis[d] ? s[d] : 7'h7F, vis[d] ? dpo[d] : 1'b1, 1'(j == 0)};
      eb = (j % 4 == 0) ? {BLANK, 1'(j == 0)} : e;
      chk(name, {an, seg, dp, frame_tick}, e);
      chk({name, "_b"}, {an_b, seg_b, dp_b, tick_b}, eb);
      if (mid[0] && j == 5) begin value = v5; load = 1'b1; end
      if (mid[1] && j == 9) begin value = v9; load = 1'b1; end
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] lz_vis;
    int b;
    n_tests  = 0;
    n_fail   = 0;
    k        = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    digit_en = '0;

    vecs[0] = '{16'h12AF, 4'b0100, 4'b1111, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    vecs[1] = '{16'h3456, 4'b0000, 4'b1111, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
    vecs[2] = '{16'h789B, 4'b1001, 4'b1111, {7'b1111000, 7'b0000000, 7'b0011000, 7'b0000011}};
    vecs[3] = '{16'hCDE0, 4'b1111, 4'b1101, {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}};
    vecs[4] = '{16'h0E00, 4'b0000, 4'b0100, {7'b1000000, 7'b0000110, 7'b1000000, 7'b1000000}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset", {an, seg, dp, frame_tick}, {BLANK, 1'b0});
    chk("reset_b", {an_b, seg_b, dp_b, tick_b}, {BLANK, 1'b0});
    rst = 1'b0;
    k   = 0;

    check_idle(32);

    for (int v = 0; v < 5; v++) begin
      load_vec(vecs[v].value, vecs[v].dpv, vecs[v].en);
      wait_frame();
      check_frame($sformatf("vec%0d", v), vecs[v].seg, ~vecs[v].dpv, vecs[v].en,
                  2'b00, 16'h0, 16'h0);
    end

    // Load mid-frame must wait for the boundary; the last of two loads wins.
    load_vec(16'h1111, 4'b0000, 4'b1111);
    wait_frame();
    check_frame("ones", {4{7'b1111001}}, 4'hF, 4'hF, 2'b01, 16'h2222, 16'h0);
    check_frame("twos", {4{7'b0100100}}, 4'hF, 4'hF, 2'b11, 16'h5555, 16'h6666);
    check_frame("sixes", {4{7'b0000010}}, 4'hF, 4'hF, 2'b00, 16'h0, 16'h0);

    // Load on the boundary cycle bypasses pending and also updates it.
    b = 0;
    while ((k % 16) != 15 && b < 20) begin
      step();
      b++;
    end
    value = 16'h3333;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("bnd_last_six", {an, seg, dp, frame_tick}, {4'b0111, 7'b0000010, 1'b1, 1'b0});
    step();
    check_frame("bypass", {4{7'b0110000}}, 4'hF, 4'hF, 2'b00, 16'h0, 16'h0);
    check_frame("bypass_pend", {4{7'b0110000}}, 4'hF, 4'hF, 2'b00, 16'h0, 16'h0);

    // Asynchronous reset in the middle of digit 2's slot.
    b = 0;
    while (((k - 1) % 16) != 9 && b < 20) begin
      step();
      b++;
    end
    chk("pre_rst", {an, seg, dp, frame_tick}, {4'b1011, 7'b0110000, 1'b1, 1'b0});
    chk("pre_rst_b", {an_b, seg_b, dp_b, tick_b}, {4'b1011, 7'b0110000, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {an, seg, dp, frame_tick}, {BLANK, 1'b0});
    chk("async_rst_b", {an_b, seg_b, dp_b, tick_b}, {BLANK, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    k   = 0;
    check_idle(32);

`ifdef SSD_LZ_BLANK_EN
    lz_vis = 4'b0011;
`else
    lz_vis = 4'b1111;
`endif
    load_vec(16'h0050, 4'b0000, 4'b1111);
    wait_frame();
    check_frame("lz", {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, 4'hF, lz_vis,
                2'b00, 16'h0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
